// File: rtl/ddr3_ui_pkg.sv
// Shared command codes, burst geometry and executor state encoding
// for the DDR3 UI responder.
package ddr3_ui_pkg;

    localparam logic [2:0] CMD_WRITE    = 3'b000;
    localparam logic [2:0] CMD_READ     = 3'b001;
    localparam int         BL8_ADDR_INC = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_WDATA = 2'd1
    } exec_state_t;

endpackage

// File: rtl/ui_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through output, used for the
// command queue and the write-data queue of the UI responder.
module ui_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ddr3_ui_responder.sv
// Memory-controller end of the 7-series MIG app_* interface: queues commands
// and write data, executes them in order against a burst RAM, returns reads.
module ddr3_ui_responder
    import ddr3_ui_pkg::*;
#(
    parameter int ADDR_WIDTH   = 30,
    parameter int DATA_WIDTH   = 256,
    parameter int MEM_AW       = 10,
    parameter int RD_LATENCY   = 8,
    parameter int CALIB_CYCLES = 64,
    parameter int STALL_PERIOD = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    init_calib_complete,
    input  logic                    app_en,
    input  logic [2:0]              app_cmd,
    input  logic [ADDR_WIDTH-1:0]   app_addr,
    output logic                    app_rdy,
    input  logic                    app_wdf_wren,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data,
    input  logic                    app_wdf_end,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    app_rd_data_valid,
    output logic                    app_rd_data_end,
    output logic                    err,
    output logic [31:0]             wr_count,
    output logic [31:0]             rd_count,
    output exec_state_t             dbg_state
);

    localparam int          CMD_W       = 3 + ADDR_WIDTH;
    localparam int          MASK_W      = DATA_WIDTH / 8;
    localparam int          WDF_W       = DATA_WIDTH + MASK_W;
    localparam int          BURST_SHIFT = $clog2(BL8_ADDR_INC);
    localparam logic [31:0] STALL_LAST  = (STALL_PERIOD == 0) ? 32'd0 : 32'(STALL_PERIOD - 1);

    logic [31:0] calib_cnt;
    logic        calib;
    logic [31:0] stall_cnt;
    logic        stall;

    logic                  cmd_full, cmd_empty, cmd_pop;
    logic [CMD_W-1:0]      cmd_head;
    logic [2:0]            cmd_count_unused;
    logic                  wdf_full, wdf_empty, wdf_pop;
    logic [WDF_W-1:0]      wdf_head;
    logic [2:0]            wdf_count_unused;

    logic [2:0]            head_cmd;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [MEM_AW-1:0]     head_idx;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic [MASK_W-1:0]     head_wmask;
    logic                  unused_addr_hi;

    exec_state_t state, state_next;
    logic        exec_write, exec_read, bad_cmd, misaligned;

    logic [DATA_WIDTH-1:0] ram [2**MEM_AW];
    logic [RD_LATENCY-1:0] pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            calib_cnt <= '0;
            calib     <= 1'b0;
        end else if (!calib) begin
            calib_cnt <= calib_cnt + 32'd1;
            if (calib_cnt == 32'(CALIB_CYCLES - 1)) calib <= 1'b1;
        end
    end

    // Stall counter only runs once calibrated, so the first ready cycle is never stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (calib && STALL_PERIOD != 0) begin
            stall_cnt <= (stall_cnt == STALL_LAST) ? 32'd0 : stall_cnt + 32'd1;
        end
    end

    assign stall = (STALL_PERIOD != 0) && calib && (stall_cnt == STALL_LAST);

    // Handshakes: a command transfers on a cycle where app_en && app_rdy, a write
    // beat where app_wdf_wren && app_wdf_rdy; ready never depends on valid or payload.
    assign app_rdy             = calib && !cmd_full && !stall;
    assign app_wdf_rdy         = calib && !wdf_full && !stall;
    assign init_calib_complete = calib;

    ui_sync_fifo #(.WIDTH(CMD_W), .DEPTH(4)) u_cmd_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (app_en && app_rdy),
        .push_data ({app_cmd, app_addr}),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty),
        .count     (cmd_count_unused)
    );

    ui_sync_fifo #(.WIDTH(WDF_W), .DEPTH(4)) u_wdf_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (app_wdf_wren && app_wdf_rdy),
        .push_data ({app_wdf_data, app_wdf_mask}),
        .pop       (wdf_pop),
        .pop_data  (wdf_head),
        .full      (wdf_full),
        .empty     (wdf_empty),
        .count     (wdf_count_unused)
    );

    assign head_cmd       = cmd_head[CMD_W-1 -: 3];
    assign head_addr      = cmd_head[ADDR_WIDTH-1:0];
    assign head_idx       = head_addr[BURST_SHIFT +: MEM_AW];
    assign head_wdata     = wdf_head[WDF_W-1 -: DATA_WIDTH];
    assign head_wmask     = wdf_head[MASK_W-1:0];
    assign unused_addr_hi = ^head_addr[ADDR_WIDTH-1:BURST_SHIFT+MEM_AW];
    assign misaligned     = (exec_write || exec_read) && (head_addr[BURST_SHIFT-1:0] != '0);
    assign dbg_state      = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_pop    = 1'b0;
        wdf_pop    = 1'b0;
        exec_write = 1'b0;
        exec_read  = 1'b0;
        bad_cmd    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cmd_empty) begin
                    if (head_cmd == CMD_WRITE) begin
                        if (!wdf_empty) begin
                            exec_write = 1'b1;
                            cmd_pop    = 1'b1;
                            wdf_pop    = 1'b1;
                        end else begin
                            state_next = ST_WAIT_WDATA;
                        end
                    end else if (head_cmd == CMD_READ) begin
                        exec_read = 1'b1;
                        cmd_pop   = 1'b1;
                    end else begin
                        bad_cmd = 1'b1;
                        cmd_pop = 1'b1;
                    end
                end
            end
            ST_WAIT_WDATA: begin
                if (!wdf_empty) begin
                    exec_write = 1'b1;
                    cmd_pop    = 1'b1;
                    wdf_pop    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (exec_write) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!head_wmask[b]) ram[head_idx][b*8 +: 8] <= head_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
        end else begin
            pipe_valid[0] <= exec_read;
            pipe_data[0]  <= ram[head_idx];
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign app_rd_data       = pipe_data[RD_LATENCY-1];
    assign app_rd_data_valid = pipe_valid[RD_LATENCY-1];
    assign app_rd_data_end   = pipe_valid[RD_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err      <= 1'b0;
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (misaligned || bad_cmd || (app_wdf_wren && !app_wdf_end)) err <= 1'b1;
            if (exec_write) wr_count <= wr_count + 32'd1;
            if (exec_read)  rd_count <= rd_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_ddr3_ui_responder.sv
// Directed scoreboard bench for ddr3_ui_responder: drivers push expected read
// data into exp_q, an independent monitor pops it whenever read data appears.
module tb_ddr3_ui_responder;
    import ddr3_ui_pkg::*;

    localparam int AW    = 30;
    localparam int DW    = 256;
    localparam int MW    = DW / 8;
    localparam int LAT   = 8;
    localparam int CALIB = 64;
    localparam int STALL = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           init_calib_complete;
    logic           app_en = 1'b0;
    logic [2:0]     app_cmd = 3'b000;
    logic [AW-1:0]  app_addr = '0;
    logic           app_rdy;
    logic           app_wdf_wren = 1'b0;
    logic [DW-1:0]  app_wdf_data = '0;
    logic           app_wdf_end = 1'b1;
    logic [MW-1:0]  app_wdf_mask = '0;
    logic           app_wdf_rdy;
    logic [DW-1:0]  app_rd_data;
    logic           app_rd_data_valid;
    logic           app_rd_data_end;
    logic           err;
    logic [31:0]    wr_count;
    logic [31:0]    rd_count;
    exec_state_t    dbg_state;

    int checks = 0;
    int failures = 0;
    int exp_wr = 0;
    int exp_rd = 0;
    logic [DW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ddr3_ui_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(10), .RD_LATENCY(LAT),
        .CALIB_CYCLES(CALIB), .STALL_PERIOD(STALL)
    ) dut (
        .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .err(err), .wr_count(wr_count), .rd_count(rd_count), .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (app_rd_data_valid) begin
            chk("rd_data_end", DW'(app_rd_data_end), DW'(app_rd_data_valid));
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_valid: got data %h expected no read data", app_rd_data);
            end else begin
                chk("rd_data", app_rd_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
        int n = 0;
        app_en = 1'b1; app_cmd = c; app_addr = a;
        while (!app_rdy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL cmd_accept_timeout: app_rdy=%0b after %0d cycles, required 1", app_rdy, n);
        end
        @(negedge clk);
        app_en = 1'b0;
    endtask

    task automatic send_wdata(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic e);
        int n = 0;
        app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = e;
        while (!app_wdf_rdy && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL wdf_accept_timeout: app_wdf_rdy=%0b after %0d cycles, required 1", app_wdf_rdy, n);
        end
        @(negedge clk);
        app_wdf_wren = 1'b0; app_wdf_end = 1'b1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        fork
            send_cmd(CMD_WRITE, a);
            send_wdata(d, m, 1'b1);
        join
        exp_wr++;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] expv);
        exp_q.push_back(expv);
        send_cmd(CMD_READ, a);
        exp_rd++;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d reads outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b1;
        exp_q.delete();
        exp_wr = 0; exp_rd = 0;
        repeat (3) @(negedge clk);
        chk("rst_calib", DW'(init_calib_complete), '0);
        chk("rst_app_rdy", DW'(app_rdy), '0);
        chk("rst_wdf_rdy", DW'(app_wdf_rdy), '0);
        chk("rst_err", DW'(err), '0);
        chk("rst_wr_count", DW'(wr_count), '0);
        chk("rst_rd_count", DW'(rd_count), '0);
        reset = 1'b0;
        for (int k = 1; k <= CALIB; k++) begin
            @(negedge clk);
            if (k == CALIB - 1) chk("calib_early", DW'(init_calib_complete), '0);
        end
        chk("calib_done", DW'(init_calib_complete), DW'(1));
        chk("calib_app_rdy", DW'(app_rdy), DW'(1));
        chk("calib_wdf_rdy", DW'(app_wdf_rdy), DW'(1));
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] base, input int i);
        return {8{base + 32'(i)}};
    endfunction

    // ---------------- main stimulus ----------------
    initial begin
        int n, hi, lows, diff;

        // Reset and calibration timing.
        @(negedge clk);
        apply_reset();

        // Basic write then read, with exact read latency.
        do_write('0, {32{8'hA5}}, '0);
        exp_q.push_back({32{8'hA5}});
        exp_rd++;
        send_cmd(CMD_READ, '0);
        n = 0;
        while (!app_rd_data_valid && n < 50) begin @(negedge clk); n++; end
        chk("rd_latency", DW'(n), DW'(LAT));
        @(negedge clk);
        chk("wr_count_1", DW'(wr_count), DW'(1));
        chk("rd_count_1", DW'(rd_count), DW'(1));

        // Four write commands without data fill the command FIFO.
        for (int i = 0; i < 4; i++) send_cmd(CMD_WRITE, AW'(i * 8));
        app_en = 1'b1; app_cmd = CMD_WRITE; app_addr = AW'(32);
        hi = 0;
        for (int i = 0; i < 10; i++) begin hi += int'(app_rdy); @(negedge clk); end
        chk("cmd_full_rdy_low", DW'(hi), '0);
        chk("wait_wdata_state", DW'(dbg_state), DW'(ST_WAIT_WDATA));
        fork
            send_cmd(CMD_WRITE, AW'(32));
            for (int i = 0; i < 5; i++) send_wdata(pat(32'h3000_0000, i), '0, 1'b1);
        join
        exp_wr += 5;
        for (int i = 0; i < 5; i++) do_read(AW'(i * 8), pat(32'h3000_0000, i));
        wait_drain();

        // Byte mask: only the low four bytes take the zero write.
        do_write(AW'(64), '1, '0);
        do_write(AW'(64), '0, 32'hFFFF_FFF0);
        do_read(AW'(64), {{28{8'hFF}}, 32'h0000_0000});
        wait_drain();

        // Misaligned address sets err; high address bits alias onto burst 0.
        chk("err_clear", DW'(err), '0);
        do_write(AW'(3), {32{8'h5A}}, '0);
        repeat (2) @(negedge clk);
        chk("err_misaligned", DW'(err), DW'(1));
        do_read(AW'(8 * 1024), {32{8'h5A}});
        wait_drain();
        chk("err_sticky", DW'(err), DW'(1));

        // Stall injection: one stalled cycle in every five while idle.
        lows = 0; diff = 0;
        for (int i = 0; i < 20; i++) begin
            lows += int'(!app_rdy);
            diff += int'(app_rdy != app_wdf_rdy);
            @(negedge clk);
        end
        chk("stall_low_cycles", DW'(lows), DW'(4));
        chk("stall_rdy_match", DW'(diff), '0);
        fork
            for (int i = 0; i < 8; i++) send_cmd(CMD_WRITE, AW'(256 + 8 * i));
            for (int i = 0; i < 8; i++) send_wdata(pat(32'hC0DE_0000, i), '0, 1'b1);
        join
        exp_wr += 8;
        for (int i = 0; i < 8; i++) do_read(AW'(256 + 8 * i), pat(32'hC0DE_0000, i));
        wait_drain();
        chk("wr_count_total", DW'(wr_count), DW'(exp_wr));
        chk("rd_count_total", DW'(rd_count), DW'(exp_rd));

        // Reset with a read in flight: its data must never appear.
        send_cmd(CMD_READ, '0);
        repeat (2) @(negedge clk);
        apply_reset();

        // Undefined command code: err, discarded, executor keeps going.
        chk("err_after_reset", DW'(err), '0);
        send_cmd(3'b010, '0);
        repeat (3) @(negedge clk);
        chk("err_bad_cmd", DW'(err), DW'(1));
        chk("bad_cmd_no_write", DW'(wr_count), '0);
        chk("bad_cmd_no_read", DW'(rd_count), '0);
        chk("bad_cmd_idle", DW'(dbg_state), DW'(ST_IDLE));
        do_read(AW'(64), {{28{8'hFF}}, 32'h0000_0000});
        wait_drain();

        // Write beat without app_wdf_end.
        apply_reset();
        send_wdata({32{8'h11}}, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("err_wdf_end", DW'(err), DW'(1));

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", DW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ddr3_ui_responder.md
Name: ddr3_ui_responder

Overview:
Simulation-grade, synthesizable responder for the 7-series MIG user interface (UI), i.e. the memory-controller end of the app_* protocol.
- Accepts write and read commands plus write data from a UI initiator such as the DDR3 traffic tester.
- Stores bursts in an internal RAM and returns read data in order, after a fixed latency.
- Replaces the MIG and DDR3 model in fast testbenches.
- Provides optional backpressure injection to exercise initiator stall paths.

Parameters:
ADDR_WIDTH, 30, width of app_addr.
DATA_WIDTH, 256, UI data width; one BL8 burst is one UI beat.
MEM_AW, 10, log2 of the RAM depth in bursts.
RD_LATENCY, 8, cycles from read execution to app_rd_data_valid; minimum 1.
CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.
STALL_PERIOD, 0, when nonzero, app_rdy and app_wdf_rdy are forced low for one cycle every STALL_PERIOD cycles.

Ports:
clk  in  1  UI clock
reset  in  1  asynchronous, active-high reset
init_calib_complete  out  1  calibration-done indication
app_en  in  1  command valid
app_cmd  in  3  000 = write, 001 = read
app_addr  in  ADDR_WIDTH  word address; BL8-aligned
app_rdy  out  1  command accept
app_wdf_wren  in  1  write data valid
app_wdf_data  in  DATA_WIDTH  write data
app_wdf_end  in  1  last beat of burst (always 1 for this configuration)
app_wdf_mask  in  DATA_WIDTH/8  byte mask; 1 = byte not written
app_wdf_rdy  out  1  write data accept
app_rd_data  out  DATA_WIDTH  read data
app_rd_data_valid  out  1  read data strobe
app_rd_data_end  out  1  last read beat; equal to app_rd_data_valid
err  out  1  sticky protocol error
wr_count  out  32  number of executed writes
rd_count  out  32  number of executed reads

Behaviour:
Reset state: all outputs 0, both FIFOs empty, read pipe cleared, calibration and stall counters cleared. RAM contents are not cleared and are undefined until written.

Calibration:
- The counter runs from reset release; init_calib_complete rises after CALIB_CYCLES cycles and stays high.
- While it is low, app_rdy and app_wdf_rdy are 0.

Acceptance rules:
- Command FIFO: depth 4, stores {cmd, addr}. A command is accepted when app_en && app_rdy.
- app_rdy = calib && !cmd_full && !stall. It does not depend on app_cmd.
- Write data FIFO: depth 4, stores {data, mask}. A beat is accepted when app_wdf_wren && app_wdf_rdy.
- app_wdf_rdy = calib && !wdf_full && !stall.
- Write data may arrive before, with, or after its command; beats pair with write commands strictly in order.

Executor (one command per cycle max, in order, FSM):
- IDLE: when the command FIFO is non-empty, dispatch the head entry.
- Write: executes only when the data FIFO is non-empty. It pops both FIFOs and updates the RAM at index app_addr[3 +: MEM_AW], honouring the mask. wr_count increments. While no data is present the FSM stays in WAIT_WDATA and the command FIFO keeps filling.
- Read: pops the command, reads the RAM and pushes the result into a RD_LATENCY-deep valid/data shift pipe. rd_count increments.
- Read-after-write to the same address returns the new data, because execution is in order.

Error and addressing rules:
- app_addr[2:0] nonzero: err is set; the command still executes using the aligned index.
- app_cmd not 000/001: err is set; the command is popped and discarded.
- app_wdf_end = 0 with wren: err is set.
- Address bits above MEM_AW+3 are ignored, so addresses alias modulo 2^MEM_AW bursts.

Stall injection: a free-running counter that is active only after calibration; the stall pulse lasts 1 cycle.

Reset mid-operation: FIFOs, the pipe and pending reads are discarded; no read data is returned for commands accepted before reset.

Counters wrap at 2^32.

Decomposition:
- Package ddr3_ui_pkg: CMD_WRITE = 3'b000, CMD_READ = 3'b001, BL8_ADDR_INC = 8, executor state encodings.
- Sub-module ui_sync_fifo: parameterized width and depth, with full, empty and count outputs. It is instantiated twice (command FIFO and write-data FIFO).

Test Plan:
1. Reset, then idle: init_calib_complete rises exactly 64 cycles after reset release; app_rdy and app_wdf_rdy are 1 from that cycle.
2. Write 0xA5..A5 at address 0, then read address 0 → app_rd_data = 0xA5..A5 with valid and end high exactly 8 cycles after read execution; wr_count = 1, rd_count = 1.
3. Five write commands with no data → app_rdy drops after 4 accepted; supplying data drains them in order; readback of addresses 0, 8, ..., 32 matches.
4. Write all-ones, then write zeros with mask 0xFFFF_FFF0, then read → only the low 4 bytes are 0, the rest stay 0xFF.
5. Address 0x3 write, and app_cmd = 3'b010 → err = 1 and stays set; address 8·2^10 read returns address 0 data.
6. STALL_PERIOD = 5 with back-to-back traffic → app_rdy is low one cycle in five; no command is lost and counts match the issued totals.
